// File: rtl/win_mc.sv
// win_mc: multi-channel complex (I/Q) time-domain window multiplier.
// All NCH lanes share one run-time-loadable coefficient per sample. The block
// keeps its own per-frame sample index and has a fixed 3-clock latency:
// S1 coefficient read, S2 multiply, S3 scale/saturate.
// Build option: define WIN_ROUND_EN for round-half-up at S3; the default
// build truncates (floor).
module win_mc #(
   parameter int DWIDTH = 16,
   parameter int CWIDTH = 18,
   parameter int NWIN   = 32,
   parameter int IWIDTH = $clog2(NWIN),
   parameter int NCH    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     coef_we,
   input  logic [IWIDTH-1:0]        coef_addr,
   input  logic [CWIDTH-1:0]        coef_data,
   input  logic                     dv_in,
   input  logic                     sof_in,
   input  logic [NCH*DWIDTH-1:0]    din_real,
   input  logic [NCH*DWIDTH-1:0]    din_imag,
   output logic                     dv_out,
   output logic                     sof_out,
   output logic [NCH*DWIDTH-1:0]    dout_real,
   output logic [NCH*DWIDTH-1:0]    dout_imag,
   output logic                     frame_err
);

   localparam int PW = DWIDTH + CWIDTH;
   localparam logic [CWIDTH-1:0]  C_ONE  = {1'b0, {(CWIDTH-1){1'b1}}};
   localparam logic [IWIDTH-1:0]  C_IZERO = {IWIDTH{1'b0}};
   localparam logic [IWIDTH-1:0]  C_IONE  = {{(IWIDTH-1){1'b0}}, 1'b1};
   localparam logic signed [PW:0] C_RND  = {{(PW-CWIDTH+2){1'b0}}, 1'b1, {(CWIDTH-2){1'b0}}};
   localparam logic signed [PW:0] C_MAX  = {{(PW-DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
   localparam logic signed [PW:0] C_MIN  = {{(PW-DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};

   // Scale a Q1.(CWIDTH-1) product back to sample range and clamp it.
   function automatic logic [DWIDTH-1:0] scale_sat(input logic signed [PW-1:0] p);
      logic signed [PW:0] t;
      t = {p[PW-1], p};
`ifdef WIN_ROUND_EN
      t = t + C_RND;
`endif
      t = t >>> (CWIDTH-1);
      if (t > C_MAX) begin
         return C_MAX[DWIDTH-1:0];
      end else if (t < C_MIN) begin
         return C_MIN[DWIDTH-1:0];
      end else begin
         return t[DWIDTH-1:0];
      end
   endfunction

   // Coefficient RAM: not touched by reset, powers up at ~1.0 everywhere.
   logic [CWIDTH-1:0]          r_coef [NWIN] = '{default: C_ONE};
   logic [CWIDTH-1:0]          r_coef_q;

   logic [IWIDTH-1:0]          r_idx;
   logic [IWIDTH-1:0]          w_idx;
   logic                       r_frame_err;

   logic                       r_v1, r_sof1;
   logic [NCH*DWIDTH-1:0]      r_re1, r_im1;
   logic                       r_v2, r_sof2;
   logic signed [PW-1:0]       r_pre2 [NCH];
   logic signed [PW-1:0]       r_pim2 [NCH];
   logic [NCH*DWIDTH-1:0]      w_sre, w_sim;

   logic                       r_dv_out, r_sof_out;
   logic [NCH*DWIDTH-1:0]      r_dout_real, r_dout_imag;

   // Index used by the sample currently on the inputs: a frame start forces 0.
   always_comb begin
      w_idx = r_idx;
      if (sof_in) begin
         w_idx = C_IZERO;
      end else begin
         w_idx = r_idx;
      end
   end

   // Per-frame index counter (wraps at NWIN) and short-frame detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx       <= C_IZERO;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= dv_in & sof_in & (r_idx != C_IZERO);
         if (dv_in) begin
            r_idx <= w_idx + C_IONE;
         end
      end
   end

   // Coefficient RAM write port and read-first registered read (S1).
   always_ff @(posedge clk) begin
      if (coef_we) begin
         r_coef[coef_addr] <= coef_data;
      end
      r_coef_q <= r_coef[w_idx];
   end

   // S1: delay lane data alongside the coefficient read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1   <= 1'b0;
         r_sof1 <= 1'b0;
         r_re1  <= {(NCH*DWIDTH){1'b0}};
         r_im1  <= {(NCH*DWIDTH){1'b0}};
      end else begin
         r_v1   <= dv_in;
         r_sof1 <= dv_in & (w_idx == C_IZERO);
         r_re1  <= din_real;
         r_im1  <= din_imag;
      end
   end

   // S2: full-precision signed multiply per lane, I and Q separately.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v2   <= 1'b0;
         r_sof2 <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            r_pre2[k] <= {PW{1'b0}};
            r_pim2[k] <= {PW{1'b0}};
         end
      end else begin
         r_v2   <= r_v1;
         r_sof2 <= r_sof1;
         for (int k = 0; k < NCH; k++) begin
            r_pre2[k] <= $signed(r_re1[k*DWIDTH +: DWIDTH]) * $signed(r_coef_q);
            r_pim2[k] <= $signed(r_im1[k*DWIDTH +: DWIDTH]) * $signed(r_coef_q);
         end
      end
   end

   // S3 datapath: scale and saturate every lane.
   always_comb begin
      w_sre = {(NCH*DWIDTH){1'b0}};
      w_sim = {(NCH*DWIDTH){1'b0}};
      for (int k = 0; k < NCH; k++) begin
         w_sre[k*DWIDTH +: DWIDTH] = scale_sat(r_pre2[k]);
         w_sim[k*DWIDTH +: DWIDTH] = scale_sat(r_pim2[k]);
      end
   end

   // S3 output registers: data updates only on valid samples, held otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dv_out    <= 1'b0;
         r_sof_out   <= 1'b0;
         r_dout_real <= {(NCH*DWIDTH){1'b0}};
         r_dout_imag <= {(NCH*DWIDTH){1'b0}};
      end else begin
         r_dv_out  <= r_v2;
         r_sof_out <= r_sof2;
         if (r_v2) begin
            r_dout_real <= w_sre;
            r_dout_imag <= w_sim;
         end
      end
   end

   assign dv_out    = r_dv_out;
   assign sof_out   = r_sof_out;
   assign dout_real = r_dout_real;
   assign dout_imag = r_dout_imag;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_win_mc.sv
// Self-checking bench for win_mc (DWIDTH=16, CWIDTH=18, NWIN=32, NCH=2).
// Expected outputs are pushed to a scoreboard queue when a sample is driven
// and compared by a monitor when dv_out appears; scenario tasks add their own
// inline checks.
`timescale 1ns/1ps
module tb_win_mc;
   localparam int DW = 16;
   localparam int CW = 18;
   localparam int NW = 32;
   localparam int IW = 5;
   localparam int NC = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              coef_we;
   logic [IW-1:0]     coef_addr;
   logic [CW-1:0]     coef_data;
   logic              dv_in, sof_in;
   logic [NC*DW-1:0]  din_real, din_imag;
   logic              dv_out, sof_out, frame_err;
   logic [NC*DW-1:0]  dout_real, dout_imag;

   always #5 clk = ~clk;

   win_mc #(.DWIDTH(DW), .CWIDTH(CW), .NWIN(NW), .NCH(NC)) dut (
      .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .dv_in(dv_in), .sof_in(sof_in),
      .din_real(din_real), .din_imag(din_imag), .dv_out(dv_out),
      .sof_out(sof_out), .dout_real(dout_real), .dout_imag(dout_imag),
      .frame_err(frame_err)
   );

   typedef struct {
      int               due;
      bit               sof;
      logic [NC*DW-1:0] re;
      logic [NC*DW-1:0] im;
   } exp_t;

   exp_t              q[$];
   int                cyc = 0;
   int                n_checks = 0;
   int                n_pass = 0;
   int                m_idx = 0;
   logic signed [CW-1:0] m_coef [NW];

`ifdef WIN_ROUND_EN
   localparam logic [15:0] EXP_RE1 = 16'd32767;
`else
   localparam logic [15:0] EXP_RE1 = 16'd32766;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Reference arithmetic: sample * Q1.17 coefficient, scaled and clamped.
   function automatic logic [15:0] ws(input logic signed [15:0] x, input logic signed [17:0] c);
      longint p;
      p = longint'(x) * longint'(c);
`ifdef WIN_ROUND_EN
      p = p + 64'sd65536;
`endif
      p = p >>> 17;
      if (p > 64'sd32767) p = 64'sd32767;
      else if (p < -64'sd32768) p = -64'sd32768;
      return p[15:0];
   endfunction

   // Drive one cycle of input; for a valid sample, push its expected output.
   task automatic drive(input bit dv, input bit sof, input logic [NC*DW-1:0] re, input logic [NC*DW-1:0] im);
      exp_t e;
      int   idx;
      dv_in = dv; sof_in = sof; din_real = re; din_imag = im;
      if (dv) begin
         idx   = sof ? 0 : m_idx;
         e.due = cyc + 3;
         e.sof = (idx == 0);
         for (int k = 0; k < NC; k++) begin
            e.re[k*DW +: DW] = ws(re[k*DW +: DW], m_coef[idx]);
            e.im[k*DW +: DW] = ws(im[k*DW +: DW], m_coef[idx]);
         end
         q.push_back(e);
         m_idx = (idx + 1) % NW;
      end
      @(negedge clk);
   endtask

   task automatic write_coef(input int a, input logic [CW-1:0] d);
      dv_in = 1'b0; sof_in = 1'b0;
      coef_we = 1'b1; coef_addr = IW'(a); coef_data = d;
      m_coef[a] = d;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   // Scoreboard monitor: compare every output sample against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (dv_out === 1'b1) begin
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: dv_out=1 at cycle %0d, required no output", cyc);
         end else begin
            e = q.pop_front();
            n_checks++;
            if (cyc == e.due) n_pass++;
            else $display("FAIL out_latency: output at cycle %0d, required cycle %0d", cyc, e.due);
            n_checks++;
            if (sof_out === e.sof) n_pass++;
            else $display("FAIL out_sof: sof_out=%b, required %b (cycle %0d)", sof_out, e.sof, cyc);
            n_checks++;
            if (dout_real === e.re && dout_imag === e.im) n_pass++;
            else $display("FAIL out_data: re=%h im=%h, required re=%h im=%h (cycle %0d)",
                          dout_real, dout_imag, e.re, e.im, cyc);
         end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         n_checks++;
         $display("FAIL missing_out: no dv_out at cycle %0d, required output due at %0d", cyc, q[0].due);
         void'(q.pop_front());
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({dv_out, sof_out, frame_err} === 3'b000 && dout_real === 32'h0 && dout_imag === 32'h0) n_pass++;
      else $display("FAIL reset_state: dv=%b sof=%b fe=%b re=%h im=%h, required all zero",
                    dv_out, sof_out, frame_err, dout_real, dout_imag);
      reset = 1'b0;
   endtask

   task automatic test_powerup();
      drive(1'b1, 1'b1, {16'h0000, 16'h7FFF}, {16'h0000, 16'h8000});
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (dv_out === 1'b1 && sof_out === 1'b1) n_pass++;
      else $display("FAIL powerup_valid: dv=%b sof=%b, required 1 1", dv_out, sof_out);
      n_checks++;
      if (dout_real[15:0] === EXP_RE1 && dout_imag[15:0] === 16'h8000) n_pass++;
      else $display("FAIL powerup_data: re0=%h im0=%h, required %h 8000", dout_real[15:0], dout_imag[15:0], EXP_RE1);
   endtask

   task automatic test_coef_sat();
      write_coef(5, 18'h20000);
      drive(1'b1, 1'b1, $urandom(), $urandom());
      for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, $urandom(), $urandom());
      drive(1'b1, 1'b0, $urandom(), {16'h8000, 16'h1234});
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (dv_out === 1'b1 && dout_imag[31:16] === 16'h7FFF) n_pass++;
      else $display("FAIL coef_sat: dv=%b im1=%h, required 1 7fff", dv_out, dout_imag[31:16]);
      n_checks++;
      if (dout_imag[15:0] === 16'hEDCC) n_pass++;
      else $display("FAIL coef_neg_lane0: im0=%h, required edcc", dout_imag[15:0]);
   endtask

   task automatic test_wrap();
      bit fe0;
      int nout = 0;
      int sofpos[$];
      fe0 = (m_idx != 0);
      for (int j = 0; j < 83; j++) begin
         if (j < 80) drive(1'b1, j == 0, $urandom(), $urandom());
         else drive(1'b0, 1'b0, 32'h0, 32'h0);
         if (j < 80) begin
            n_checks++;
            if (frame_err === ((j == 0) ? fe0 : 1'b0)) n_pass++;
            else $display("FAIL wrap_frame_err: sample %0d fe=%b, required %b", j, frame_err, (j == 0) ? fe0 : 1'b0);
         end
         if (dv_out === 1'b1) begin
            if (sof_out === 1'b1) sofpos.push_back(nout);
            nout++;
         end
      end
      n_checks++;
      if (nout == 80) n_pass++;
      else $display("FAIL wrap_count: %0d outputs, required 80", nout);
      n_checks++;
      if (sofpos.size() == 3 && sofpos[0] == 0 && sofpos[1] == 32 && sofpos[2] == 64) n_pass++;
      else $display("FAIL wrap_sof_pos: %0d sof_out pulses (first at %0d), required 3 at 0,32,64",
                    sofpos.size(), (sofpos.size() > 0) ? sofpos[0] : -1);
   endtask

   task automatic test_short_frame();
      write_coef(12, 18'sd40000);
      drive(1'b1, 1'b1, $urandom(), $urandom());
      for (int i = 1; i < 12; i++) drive(1'b1, 1'b0, $urandom(), $urandom());
      drive(1'b1, 1'b1, $urandom(), $urandom());
      n_checks++;
      if (frame_err === 1'b1) n_pass++;
      else $display("FAIL short_frame_err: fe=%b, required 1", frame_err);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (frame_err === 1'b0) n_pass++;
      else $display("FAIL short_frame_pulse: fe=%b, required 0", frame_err);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (dv_out === 1'b1 && sof_out === 1'b1) n_pass++;
      else $display("FAIL short_frame_sof: dv=%b sof=%b, required 1 1", dv_out, sof_out);
   endtask

   task automatic test_gaps();
      bit hist[$];
      bit dv;
      for (int i = 0; i < NW; i++) write_coef(i, CW'(i * 4096));
      for (int j = 0; j < 43; j++) begin
         dv = (j < 40) && (j % 5 != 1) && (j % 5 != 3);
         hist.push_back(dv);
         drive(dv, j == 0, $urandom(), $urandom());
         if (j >= 2) begin
            n_checks++;
            if (dv_out === hist[j-2]) n_pass++;
            else $display("FAIL gaps_dv_pattern: step %0d dv_out=%b, required %b", j, dv_out, hist[j-2]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      drive(1'b1, 1'b1, $urandom(), $urandom());
      drive(1'b1, 1'b0, $urandom(), $urandom());
      reset = 1'b1; dv_in = 1'b0; sof_in = 1'b0;
      q.delete();
      m_idx = 0;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if ({dv_out, sof_out, frame_err} === 3'b000 && dout_real === 32'h0 && dout_imag === 32'h0) n_pass++;
      else $display("FAIL midreset_state: dv=%b sof=%b fe=%b re=%h im=%h, required all zero",
                    dv_out, sof_out, frame_err, dout_real, dout_imag);
      for (int j = 0; j < 3; j++) begin
         drive(1'b0, 1'b0, 32'h0, 32'h0);
         n_checks++;
         if (dv_out === 1'b0) n_pass++;
         else $display("FAIL midreset_flush: dv_out=%b at step %0d, required 0", dv_out, j);
      end
      drive(1'b1, 1'b0, $urandom(), $urandom());
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (dv_out === 1'b1 && sof_out === 1'b1) n_pass++;
      else $display("FAIL midreset_index0: dv=%b sof=%b, required 1 1", dv_out, sof_out);
   endtask

   initial begin
      reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      dv_in = 1'b0; sof_in = 1'b0; din_real = '0; din_imag = '0;
      for (int i = 0; i < NW; i++) m_coef[i] = 18'sd131071;
      @(negedge clk);
      test_reset();
      test_powerup();
      test_coef_sat();
      test_wrap();
      test_short_frame();
      test_gaps();
      test_reset_midframe();
      repeat (4) drive(1'b0, 1'b0, 32'h0, 32'h0);
      n_checks++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
